// File: rtl/pipe_reg.sv
// rtl/pipe_reg.sv - multi-stage valid/ready register pipeline with flush and occupancy count
module pipe_reg #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 3,
    localparam int OCC_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [OCC_W-1:0] occupancy
);

    logic [DEPTH-1:0] v_q, v_d;
    logic [WIDTH-1:0] d_q [DEPTH];
    logic [WIDTH-1:0] d_d [DEPTH];
    logic [DEPTH-1:0] rdy;
    logic             rdy_acc;
    logic [OCC_W-1:0] occ_cnt;

    // A stage may load when it is empty or everything downstream of it can move.
    always_comb begin
        rdy     = '0;
        rdy_acc = out_ready;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            rdy_acc = !v_q[i] || rdy_acc;
            rdy[i]  = rdy_acc;
        end
    end

    always_comb begin
        v_d = v_q;
        d_d = d_q;
        if (flush) begin
            v_d = '0;
        end else begin
            if (rdy[0]) begin
                v_d[0] = in_valid;
                d_d[0] = in_data;
            end
            for (int i = 1; i < DEPTH; i++) begin
                if (rdy[i]) begin
                    v_d[i] = v_q[i-1];
                    d_d[i] = d_q[i-1];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                d_q[i] <= '0;
            end
        end else begin
            v_q <= v_d;
            for (int i = 0; i < DEPTH; i++) begin
                d_q[i] <= d_d[i];
            end
        end
    end

    always_comb begin
        occ_cnt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occ_cnt = occ_cnt + OCC_W'(v_q[i]);
        end
    end

    assign in_ready  = rdy[0] && !flush;
    assign out_valid = v_q[DEPTH-1] && !flush;
    assign out_data  = d_q[DEPTH-1];
    assign occupancy = occ_cnt;

endmodule
